addsub_issuer: RTL and testbench
================================

# addsub_issuer

Synthesizable initiator for the 8-bit add/sub engine's start/done handshake.
- Accepts one four-operand request (A, B, C, D plus mode) on a valid/ready port and drives the engine's start/mode/operand lines.
- Waits for done, captures the 8-bit result and returns it on a valid/ready response port.
- Sits between a host/sequencer and the engine, replacing hand-driven start pulses with a protocol-correct controller.

## Interface
Parameters:
- START_CYCLES, 2: cycles op_start is held high per transaction (1..15).
- TIMEOUT_CYCLES, 64: WAIT-state cycle limit before error; used only when the watchdog is compiled in.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_mode  in  1  0/1 operation select, passed to engine.
- req_a, req_b, req_c, req_d  in  8 each  operands.
- op_start  out  1  engine start.
- op_mode  out  1  engine mode.
- op_a, op_b, op_c, op_d  out  8 each  engine operands.
- op_res  in  8  engine result.
- op_done  in  1  engine done.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_res  out  8  captured result.
- rsp_err  out  1  timeout flag; tied 0 without watchdog.
- txn_count  out  8  completed transactions, wraps 0xFF->0x00.

## Operation
- States:
  - IDLE: req_ready=1.
  - START: op_start=1 for START_CYCLES cycles.
  - WAIT: op_start=0; sample op_done.
  - RESP: rsp_valid=1; hold until rsp_ready.
- IDLE -> START on req_valid&&req_ready. Operands and mode are registered into op_* on that edge.
- op_* stay stable from START entry until return to IDLE.
- START -> WAIT after exactly START_CYCLES cycles of op_start high. op_done during START is ignored.
- WAIT -> RESP on the first cycle op_done=1. op_res is captured into rsp_res, and rsp_err is set to 0.
- RESP -> IDLE on rsp_valid&&rsp_ready. txn_count increments on that edge.
- Arithmetic is owned by the engine. The issuer never alters op_res.
- Only one transaction is in flight. No queuing: req_ready=0 outside IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, op_start=0, op_mode=0, op_a..op_d=0x00, rsp_valid=0, rsp_res=0x00, rsp_err=0, txn_count=0x00.
- Accept edge N:
  - op_start high cycles N+1..N+START_CYCLES.
  - WAIT from N+START_CYCLES+1.
- op_done seen at WAIT cycle M -> rsp_valid=1 at M+1 (one-cycle capture latency).
- rsp_ready high in the same cycle rsp_valid rises -> IDLE next cycle, req_ready=1.
- Back-to-back minimum: START_CYCLES + 3 cycles per transaction, with an immediate done and ready.
- rsp_valid and rsp_res are held unchanged while rsp_ready=0. No drop, no overwrite.
- req_valid during RESP is not accepted. Acceptance happens only in IDLE.
- Reset mid-transaction (any state) returns all outputs to reset values on the next edge. An in-flight result is discarded and txn_count is cleared.
- op_done held high across transactions: a new transaction completes only on op_done sampled in its own WAIT state.

## Configuration
- ADDSUB_TIMEOUT_EN defined: watchdog counter runs in WAIT.
  - It clears on WAIT entry.
  - When it reaches TIMEOUT_CYCLES with op_done still 0, go to RESP with rsp_err=1 and rsp_res=0x00.
  - txn_count still increments on handshake.
- ADDSUB_TIMEOUT_EN undefined:
  - No counter logic.
  - rsp_err is constant 0.
  - WAIT lasts indefinitely until op_done.

## Structure
- Shared package addsub_pkg: state enum (IDLE, START, WAIT, RESP), DATA_W=8, a request struct {mode, a, b, c, d}.
- One sub-module, addsub_watchdog: loadable down-counter with an expire output. It is instantiated only under ADDSUB_TIMEOUT_EN.
- The START_CYCLES counter is local to addsub_issuer.

## Test plan
The bench engine model asserts done 4 cycles after start falls. It computes mode0 = a+b+c+d mod 256 and mode1 = a-b-c-d mod 256.
- Reset, then request mode0 A=01 B=02 C=FF D=FE, rsp_ready=1:
  - op_start is high exactly 2 cycles.
  - rsp_res=0x00, rsp_err=0, txn_count=1.
- Request mode1 A=FE B=01 C=01 D=04 with rsp_ready=0 for 5 cycles:
  - rsp_valid and rsp_res=0xF8 hold stable.
  - req_valid pulses in this window are not accepted.
- Model raises done during START:
  - Done is ignored and op_start still completes 2 cycles.
  - The result is taken only from the done sampled in WAIT.
- Reset asserted in WAIT of request A=01 B=FF C=FF D=FF:
  - Next cycle op_start=0, rsp_valid=0, txn_count=0, req_ready=1.
- ADDSUB_TIMEOUT_EN, engine never asserts done:
  - rsp_valid after 64 WAIT cycles with rsp_err=1 and rsp_res=0x00.
  - Without the macro, rsp_valid stays 0.
- 256 back-to-back transactions: txn_count wraps to 0x00, and each transaction takes at least START_CYCLES+3 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types for the add/sub engine issuer.
// Holds the FSM state enum, data width and the request bundle.
package addsub_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              mode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
  } req_t;

  function automatic req_t pack_req(
    input logic              m,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] d
  );
    req_t r;
    r.mode = m;
    r.a    = a;
    r.b    = b;
    r.c    = c;
    r.d    = d;
    return r;
  endfunction

endpackage

// File: rtl/addsub_watchdog.sv
// addsub_watchdog: loadable down-counter, o_expire while enabled at zero.
// Ports: i_clock, i_reset (sync, high), i_load/i_load_val, i_en, o_expire.
module addsub_watchdog
  import addsub_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/addsub_issuer.sv
// addsub_issuer: one-at-a-time start/done initiator for the add/sub engine.
// Ports: clock, reset (sync, high); req_valid/ready + req_mode/a..d in;
//   op_start/mode/a..d out, op_res/op_done in; rsp_valid/ready, rsp_res,
//   rsp_err out; txn_count = completed handshakes (wraps).
// Macro ADDSUB_TIMEOUT_EN: adds a WAIT watchdog (TIMEOUT_CYCLES), else
//   rsp_err is tied 0 and WAIT lasts until op_done.
module addsub_issuer
  import addsub_pkg::*;
#(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [DATA_W-1:0] req_c,
  input  logic [DATA_W-1:0] req_d,
  output logic              op_start,
  output logic              op_mode,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_c,
  output logic [DATA_W-1:0] op_d,
  input  logic [DATA_W-1:0] op_res,
  input  logic              op_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_err,
  output logic [7:0]        txn_count
);

  localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_scnt;
  req_t              r_req;
  logic              r_start;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_res;
  logic [7:0]        r_txn;
  logic              w_start_last;

  assign w_start_last = (r_scnt == START_LAST);

`ifdef ADDSUB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic r_rsp_err;
  logic w_wd_load;
  logic w_wd_expire;

  // Loaded on the START->WAIT edge so the first WAIT cycle counts.
  assign w_wd_load = (r_state == START) && w_start_last;

  addsub_watchdog #(
    .CNT_W(WD_W)
  ) u_wd (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_load    (w_wd_load),
    .i_load_val(WD_W'(TIMEOUT_CYCLES - 1)),
    .i_en      (r_state == WAIT),
    .o_expire  (w_wd_expire)
  );

  assign rsp_err = r_rsp_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_scnt      <= '0;
      r_req       <= '0;
      r_start     <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_txn       <= '0;
`ifdef ADDSUB_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req       <= pack_req(req_mode, req_a, req_b,
                                    req_c, req_d);
            r_state     <= START;
            r_scnt      <= '0;
            r_start     <= 1'b1;
            r_req_ready <= 1'b0;
          end
        end
        START: begin
          // op_done is deliberately not looked at here.
          if (w_start_last) begin
            r_state <= WAIT;
            r_start <= 1'b0;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        WAIT: begin
          if (op_done) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_res   <= op_res;
`ifdef ADDSUB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end
`ifdef ADDSUB_TIMEOUT_EN
          else if (w_wd_expire) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_res   <= '0;
            r_rsp_err   <= 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_txn       <= r_txn + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign op_start  = r_start;
  assign op_mode   = r_req.mode;
  assign op_a      = r_req.a;
  assign op_b      = r_req.b;
  assign op_c      = r_req.c;
  assign op_d      = r_req.d;
  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign txn_count = r_txn;

endmodule

// File: tb/tb_addsub_issuer.sv
// tb_addsub_issuer: scoreboard bench for addsub_issuer.
// Engine model answers 4 cycles after op_start falls (or as a test needs).
`timescale 1ns/1ps
module tb_addsub_issuer;

  localparam int SC = 2;
  localparam int TO = 64;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_mode;
  logic [7:0] req_a, req_b, req_c, req_d;
  logic       op_start;
  logic       op_mode;
  logic [7:0] op_a, op_b, op_c, op_d;
  logic [7:0] op_res;
  logic       op_done;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_res;
  logic       rsp_err;
  logic [7:0] txn_count;

  int n_chk;
  int n_err;

  // expected {err, res}, pushed on accept, popped on rsp_valid
  logic [8:0] sb[$];

  typedef enum int {E_NORM, E_FAST, E_EARLY, E_NEVER} eng_t;
  eng_t eng;
  int   e_cnt;
  logic e_prev;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  addsub_issuer #(
    .START_CYCLES  (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mode (req_mode),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_c    (req_c),
    .req_d    (req_d),
    .op_start (op_start),
    .op_mode  (op_mode),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_c     (op_c),
    .op_d     (op_d),
    .op_res   (op_res),
    .op_done  (op_done),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_res  (rsp_res),
    .rsp_err  (rsp_err),
    .txn_count(txn_count)
  );

  function automatic logic [7:0] calc(input logic m, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] d);
    logic [7:0] r;
    if (m) r = a - b - c - d;
    else   r = a + b + c + d;
    return r;
  endfunction

  // Engine model, driven on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      op_done = 1'b0;
      op_res  = 8'h00;
      e_cnt   = 0;
      e_prev  = 1'b0;
    end else begin
      op_done = 1'b0;
      if (op_start && eng == E_EARLY) begin
        op_done = 1'b1;
        op_res  = 8'hAA;
      end
      if (e_prev && !op_start) begin
        if (eng == E_FAST) begin
          op_done = 1'b1;
          op_res  = calc(op_mode, op_a, op_b, op_c, op_d);
        end else if (eng != E_NEVER) begin
          e_cnt = 4;
        end
      end else if (e_cnt > 0) begin
        e_cnt = e_cnt - 1;
        if (e_cnt == 0) begin
          op_done = 1'b1;
          op_res  = calc(op_mode, op_a, op_b, op_c, op_d);
        end
      end
      e_prev = op_start;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic issue(input logic m, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, output bit ok);
    req_mode  = m;
    req_a     = a;
    req_b     = b;
    req_c     = c;
    req_d     = d;
    req_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      tick;
    end
    req_valid = 1'b0;
  endtask

  task automatic count_start(output int n);
    n = 0;
    while (op_start && n < 20) begin
      n++;
      tick;
    end
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 200) begin
      tick;
      k++;
    end
  endtask

  task automatic test_reset;
    apply_reset;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    n_chk++;
    if (op_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_op_start got=%b exp=0", op_start);
    end
    n_chk++;
    if ({op_mode, op_a, op_b, op_c, op_d} !== 33'h0) begin
      n_err++;
      $display("FAIL reset_op_bus got=%h exp=0",
               {op_mode, op_a, op_b, op_c, op_d});
    end
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_res} !== 10'h0) begin
      n_err++;
      $display("FAIL reset_rsp got v=%b e=%b r=%h exp 0/0/00",
               rsp_valid, rsp_err, rsp_res);
    end
    n_chk++;
    if (txn_count !== 8'h00) begin
      n_err++;
      $display("FAIL reset_txn got=%h exp=00", txn_count);
    end
  endtask

  task automatic test_basic;
    bit         ok;
    int         n, k;
    logic [8:0] e;
    eng       = E_NORM;
    rsp_ready = 1'b1;
    issue(1'b0, 8'h01, 8'h02, 8'hFF, 8'hFE, ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL basic_accept got=0 exp=1");
    end
    sb.push_back({1'b0, 8'h00});
    n_chk++;
    if ({op_mode, op_a, op_b, op_c, op_d} !== {1'b0, 32'h0102FFFE}) begin
      n_err++;
      $display("FAIL basic_op_bus got=%h exp=00102fffe",
               {op_mode, op_a, op_b, op_c, op_d});
    end
    count_start(n);
    n_chk++;
    if (n != SC) begin
      n_err++;
      $display("FAIL basic_start_len got=%0d exp=%0d", n, SC);
    end
    wait_rsp(k);
    n_chk++;
    if (k != 5) begin
      n_err++;
      $display("FAIL basic_wait_len got=%0d exp=5", k);
    end
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL basic_sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      n_chk++;
      if ({rsp_err, rsp_res} !== e) begin
        n_err++;
        $display("FAIL basic_rsp got=%h exp=%h", {rsp_err, rsp_res}, e);
      end
    end
    tick;
    n_chk++;
    if (txn_count !== 8'h01 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done got txn=%h v=%b rdy=%b exp 01/0/1",
               txn_count, rsp_valid, req_ready);
    end
  endtask

  task automatic test_hold;
    bit         ok;
    int         k;
    logic [8:0] e;
    eng       = E_NORM;
    rsp_ready = 1'b0;
    issue(1'b1, 8'hFE, 8'h01, 8'h01, 8'h04, ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL hold_accept got=0 exp=1");
    end
    sb.push_back({1'b0, 8'hF8});
    wait_rsp(k);
    e = 9'h0;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL hold_sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0];
      req_a     = 8'h55;
      n_chk++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_res} !== e ||
          req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d got v=%b r=%h rdy=%b exp 1/%h/0",
                 i, rsp_valid, {rsp_err, rsp_res}, req_ready, e);
      end
      tick;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_res !== 8'hF8) begin
      n_err++;
      $display("FAIL hold_end got v=%b r=%h exp 1/f8", rsp_valid, rsp_res);
    end
    tick;
    n_chk++;
    if (txn_count !== 8'h02 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_done got txn=%h rdy=%b v=%b exp 02/1/0",
               txn_count, req_ready, rsp_valid);
    end
    tick;
    n_chk++;
    if (op_start !== 1'b0) begin
      n_err++;
      $display("FAIL hold_no_accept got=%b exp=0", op_start);
    end
  endtask

  task automatic test_early_done;
    bit         ok;
    int         n, k;
    logic [8:0] e;
    eng       = E_EARLY;
    rsp_ready = 1'b1;
    issue(1'b0, 8'h10, 8'h20, 8'h30, 8'h40, ok);
    sb.push_back({1'b0, 8'hA0});
    count_start(n);
    n_chk++;
    if (n != SC) begin
      n_err++;
      $display("FAIL early_start_len got=%0d exp=%0d", n, SC);
    end
    wait_rsp(k);
    n_chk++;
    if (k != 5) begin
      n_err++;
      $display("FAIL early_wait_len got=%0d exp=5", k);
    end
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL early_sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      n_chk++;
      if ({rsp_err, rsp_res} !== e) begin
        n_err++;
        $display("FAIL early_rsp got=%h exp=%h", {rsp_err, rsp_res}, e);
      end
    end
    tick;
    n_chk++;
    if (txn_count !== 8'h03) begin
      n_err++;
      $display("FAIL early_txn got=%h exp=03", txn_count);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    int n;
    eng       = E_NORM;
    rsp_ready = 1'b1;
    issue(1'b0, 8'h01, 8'hFF, 8'hFF, 8'hFF, ok);
    sb.push_back({1'b0, 8'hFE});
    count_start(n);
    tick;
    reset = 1'b1;
    tick;
    n_chk++;
    if (op_start !== 1'b0 || rsp_valid !== 1'b0 ||
        txn_count !== 8'h00 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst got st=%b v=%b txn=%h rdy=%b exp 0/0/00/1",
               op_start, rsp_valid, txn_count, req_ready);
    end
    n_chk++;
    if ({op_mode, op_a, op_b, op_c, op_d} !== 33'h0) begin
      n_err++;
      $display("FAIL midrst_op_bus got=%h exp=0",
               {op_mode, op_a, op_b, op_c, op_d});
    end
    reset = 1'b0;
    sb.delete();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick;
    end
    n_chk++;
    if (seen) begin
      n_err++;
      $display("FAIL midrst_discard got=1 exp=0");
    end
  endtask

  task automatic test_timeout;
    bit         ok;
    int         n, k;
    logic [8:0] e;
    eng       = E_NEVER;
    rsp_ready = 1'b1;
    issue(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, ok);
    count_start(n);
`ifdef ADDSUB_TIMEOUT_EN
    sb.push_back({1'b1, 8'h00});
    wait_rsp(k);
    n_chk++;
    if (k != TO) begin
      n_err++;
      $display("FAIL to_wait_len got=%0d exp=%0d", k, TO);
    end
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL to_sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      n_chk++;
      if ({rsp_err, rsp_res} !== e) begin
        n_err++;
        $display("FAIL to_rsp got=%h exp=%h", {rsp_err, rsp_res}, e);
      end
    end
    tick;
    n_chk++;
    if (txn_count !== 8'h01) begin
      n_err++;
      $display("FAIL to_txn got=%h exp=01", txn_count);
    end
`else
    e = 9'h0;
    wait_rsp(k);
    n_chk++;
    if (rsp_valid !== 1'b0 || k != 200) begin
      n_err++;
      $display("FAIL to_none got v=%b k=%0d exp 0/200", rsp_valid, k);
    end
    n_chk++;
    if ({rsp_err, rsp_res} !== e) begin
      n_err++;
      $display("FAIL to_err got=%h exp=%h", {rsp_err, rsp_res}, e);
    end
    apply_reset;
`endif
  endtask

  task automatic test_back_to_back;
    int         sent, got, guard, last;
    bit         acc;
    logic [8:0] e;
    logic [8:0] cur;
    apply_reset;
    eng       = E_FAST;
    rsp_ready = 1'b1;
    sent      = 0;
    got       = 0;
    guard     = 0;
    last      = 0;
    req_mode  = 1'($urandom_range(0, 1));
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    req_c     = 8'($urandom);
    req_d     = 8'($urandom);
    cur       = {1'b0, calc(req_mode, req_a, req_b, req_c, req_d)};
    req_valid = 1'b1;
    while (got < 256 && guard < 4000) begin
      if (rsp_valid) begin
        got++;
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL b2b_sb_empty got=0 exp=1");
        end else begin
          e = sb.pop_front();
          n_chk++;
          if ({rsp_err, rsp_res} !== e) begin
            n_err++;
            $display("FAIL b2b_rsp_%0d got=%h exp=%h",
                     got, {rsp_err, rsp_res}, e);
          end
        end
        if (got == 256) begin
          n_chk++;
          if (txn_count !== 8'hFF) begin
            n_err++;
            $display("FAIL b2b_txn_ff got=%h exp=ff", txn_count);
          end
        end
      end
      acc = req_valid && req_ready;
      tick;
      guard++;
      if (acc) begin
        sb.push_back(cur);
        if (sent > 0) begin
          n_chk++;
          if (guard - last != SC + 3) begin
            n_err++;
            $display("FAIL b2b_period_%0d got=%0d exp=%0d",
                     sent, guard - last, SC + 3);
          end
        end
        last = guard;
        sent++;
        if (sent < 256) begin
          req_mode = 1'($urandom_range(0, 1));
          req_a    = 8'($urandom);
          req_b    = 8'($urandom);
          req_c    = 8'($urandom);
          req_d    = 8'($urandom);
          cur      = {1'b0, calc(req_mode, req_a, req_b, req_c, req_d)};
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    n_chk++;
    if (got != 256) begin
      n_err++;
      $display("FAIL b2b_count got=%0d exp=256", got);
    end
    n_chk++;
    if (txn_count !== 8'h00) begin
      n_err++;
      $display("FAIL b2b_wrap got=%h exp=00", txn_count);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_a     = 8'h00;
    req_b     = 8'h00;
    req_c     = 8'h00;
    req_d     = 8'h00;
    rsp_ready = 1'b0;
    eng       = E_NORM;
    test_reset;
    test_basic;
    test_hold;
    test_early_done;
    test_reset_mid;
    test_timeout;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
